// File: rtl/ifetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches over a req/ack handshake and
// selects the next PC from execute results when the current instruction commits.
module ifetch_unit #(
   parameter logic [31:0] RESET_PC      = 32'h0000_0000,
   parameter int          FETCH_TIMEOUT = 255
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] Addr_Result,
   input  logic        Zero,
   input  logic [31:0] Read_data_1,
   input  logic        Branch,
   input  logic        nBranch,
   input  logic        Jmp,
   input  logic        Jal,
   input  logic        Jr,
   input  logic        hold,
   input  logic [31:0] imem_rdata,
   input  logic        imem_ack,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   output logic [31:0] Instruction,
   output logic        inst_valid,
   output logic [31:0] PC_plus_4,
   output logic [31:0] link_addr,
   output logic        fetch_err
);

   typedef enum logic [1:0] {
      S_FETCH,
      S_EXEC,
      S_HALT
   } state_t;

   // The counter holds completed no-ack cycles; the cycle that would make it
   // reach FETCH_TIMEOUT is the one that raises the error.
   localparam logic [15:0] TIMEOUT_LAST = 16'(FETCH_TIMEOUT - 1);

   state_t      r_state;
   state_t      w_nextState;
   logic [31:0] r_pc;
   logic [31:0] r_instruction;
   logic [31:0] r_linkAddr;
   logic        r_fetchErr;
   logic [15:0] r_timeoutCnt;

   logic        w_fetchDone;
   logic        w_timeout;
   logic        w_commit;
   logic        w_takeBranch;
   logic [31:0] w_pcPlus4;
   logic [31:0] w_nextPcRaw;
   logic [31:0] w_nextPc;

   assign w_pcPlus4    = r_pc + 32'd4;
   assign w_fetchDone  = (r_state == S_FETCH) && imem_ack;
   assign w_timeout    = (r_state == S_FETCH) && !imem_ack && (r_timeoutCnt == TIMEOUT_LAST);
   assign w_commit     = (r_state == S_EXEC) && !hold;
   assign w_takeBranch = (Branch && Zero) || (nBranch && !Zero);

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state <= S_FETCH;
      end else begin
         r_state <= w_nextState;
      end
   end

   always_comb begin
      w_nextState = r_state;
      case (r_state)
         S_FETCH: begin
            if (imem_ack) begin
               w_nextState = S_EXEC;
            end else if (w_timeout) begin
               w_nextState = S_HALT;
            end
         end
         S_EXEC: begin
            if (!hold) begin
               w_nextState = S_FETCH;
            end
         end
         S_HALT:  w_nextState = S_HALT;
         default: w_nextState = S_FETCH;
      endcase
   end

   always_comb begin
      imem_req   = 1'b0;
      inst_valid = 1'b0;
      case (r_state)
         S_FETCH: imem_req   = 1'b1;
         S_EXEC:  inst_valid = 1'b1;
         default: ;
      endcase
   end

   // Jr outranks jumps, which outrank conditional branches.
   always_comb begin
      w_nextPcRaw = w_pcPlus4;
      if (Jr) begin
         w_nextPcRaw = Read_data_1;
      end else if (Jmp || Jal) begin
         w_nextPcRaw = {w_pcPlus4[31:28], r_instruction[25:0], 2'b00};
      end else if (w_takeBranch) begin
         w_nextPcRaw = Addr_Result;
      end
      w_nextPc = {w_nextPcRaw[31:2], 2'b00};
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_pc          <= RESET_PC;
         r_instruction <= 32'h0;
         r_linkAddr    <= 32'h0;
         r_fetchErr    <= 1'b0;
         r_timeoutCnt  <= 16'h0;
      end else begin
         if (w_fetchDone) begin
            r_instruction <= imem_rdata;
            r_timeoutCnt  <= 16'h0;
         end else if (w_timeout) begin
            r_fetchErr    <= 1'b1;
            r_timeoutCnt  <= 16'h0;
         end else if (r_state == S_FETCH) begin
            r_timeoutCnt  <= r_timeoutCnt + 16'd1;
         end
         if (w_commit) begin
            r_pc <= w_nextPc;
            if (Jal) begin
               r_linkAddr <= w_pcPlus4;
            end
         end
      end
   end

   assign imem_addr   = r_pc;
   assign PC_plus_4   = w_pcPlus4;
   assign Instruction = r_instruction;
   assign link_addr   = r_linkAddr;
   assign fetch_err   = r_fetchErr;

endmodule

// File: tb/tb_ifetch_unit.sv
// Scoreboard bench for ifetch_unit: expected fetch addresses and instruction
// words are queued as stimulus is driven and popped as the DUT presents them.
module tb_ifetch_unit;

   localparam logic [31:0] RESET_PC      = 32'h0000_0000;
   localparam int          FETCH_TIMEOUT = 4;

   logic        clock;
   logic        reset;
   logic [31:0] Addr_Result;
   logic        Zero;
   logic [31:0] Read_data_1;
   logic        Branch;
   logic        nBranch;
   logic        Jmp;
   logic        Jal;
   logic        Jr;
   logic        hold;
   logic [31:0] imem_rdata;
   logic        imem_ack;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] Instruction;
   logic        inst_valid;
   logic [31:0] PC_plus_4;
   logic [31:0] link_addr;
   logic        fetch_err;

   int checks = 0;
   int errors = 0;
   logic [31:0] addrQ[$];
   logic [31:0] instQ[$];
   logic [31:0] lastInst;

   ifetch_unit #(
      .RESET_PC(RESET_PC),
      .FETCH_TIMEOUT(FETCH_TIMEOUT)
   ) dut (
      .clock(clock),
      .reset(reset),
      .Addr_Result(Addr_Result),
      .Zero(Zero),
      .Read_data_1(Read_data_1),
      .Branch(Branch),
      .nBranch(nBranch),
      .Jmp(Jmp),
      .Jal(Jal),
      .Jr(Jr),
      .hold(hold),
      .imem_rdata(imem_rdata),
      .imem_ack(imem_ack),
      .imem_req(imem_req),
      .imem_addr(imem_addr),
      .Instruction(Instruction),
      .inst_valid(inst_valid),
      .PC_plus_4(PC_plus_4),
      .link_addr(link_addr),
      .fetch_err(fetch_err)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not end within time limit");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
      end
   endtask

   task automatic clearFlags();
      Jr = 1'b0; Jmp = 1'b0; Jal = 1'b0; Branch = 1'b0; nBranch = 1'b0;
      Zero = 1'b0; Read_data_1 = 32'h0; Addr_Result = 32'h0; hold = 1'b0;
   endtask

   // Returns at the negedge of the first FETCH cycle after reset.
   task automatic applyReset();
      @(negedge clock);
      reset = 1'b1;
      imem_ack = 1'b0;
      clearFlags();
      @(negedge clock);
      reset = 1'b0;
      addrQ.delete();
      instQ.delete();
      addrQ.push_back(RESET_PC);
      lastInst = 32'h0;
   endtask

   // Waits for a request, checks the address, acks with word and checks EXEC.
   task automatic fetchWord(input logic [31:0] word);
      int waited = 0;
      logic [31:0] expAddr;
      logic [31:0] expInst;
      while (!imem_req && waited < 20) begin
         @(negedge clock);
         waited++;
      end
      if (!imem_req) begin
         checkOutput("fetch_wait", {31'h0, imem_req}, 32'h1);
         return;
      end
      expAddr = (addrQ.size() > 0) ? addrQ.pop_front() : 32'hxxxx_xxxx;
      checkOutput("imem_addr", imem_addr, expAddr);
      checkOutput("inst_valid_fetch", {31'h0, inst_valid}, 32'h0);
      imem_ack = 1'b1;
      imem_rdata = word;
      instQ.push_back(word);
      @(negedge clock);
      imem_ack = 1'b0;
      imem_rdata = 32'h0;
      expInst = (instQ.size() > 0) ? instQ.pop_front() : 32'hxxxx_xxxx;
      checkOutput("inst_valid_exec", {31'h0, inst_valid}, 32'h1);
      checkOutput("Instruction", Instruction, expInst);
      lastInst = expInst;
   endtask

   // Starts at an EXEC negedge; holds for holdCycles, then commits with the flags.
   task automatic applyStimulus(input int holdCycles, input logic jr, input logic jmp,
                                input logic jal, input logic br, input logic nbr,
                                input logic zero, input logic [31:0] rd1,
                                input logic [31:0] addrRes, input logic [31:0] expNext);
      logic [31:0] heldAddr;
      heldAddr = imem_addr;
      Jr = jr; Jmp = jmp; Jal = jal; Branch = br; nBranch = nbr;
      Zero = zero; Read_data_1 = rd1; Addr_Result = addrRes;
      for (int i = 0; i < holdCycles; i++) begin
         hold = 1'b1;
         imem_ack = 1'b1;
         imem_rdata = 32'hBAD0_0000 | 32'(i);
         @(negedge clock);
         checkOutput("hold_valid", {31'h0, inst_valid}, 32'h1);
         checkOutput("hold_req", {31'h0, imem_req}, 32'h0);
         checkOutput("hold_pc", imem_addr, heldAddr);
         checkOutput("hold_inst", Instruction, lastInst);
      end
      hold = 1'b0;
      imem_ack = 1'b0;
      imem_rdata = 32'h0;
      addrQ.push_back(expNext);
      @(negedge clock);
      clearFlags();
   endtask

   initial begin
      reset = 1'b0;
      imem_ack = 1'b0;
      imem_rdata = 32'h0;
      clearFlags();
      applyReset();

      checkOutput("rst_req", {31'h0, imem_req}, 32'h1);
      checkOutput("rst_valid", {31'h0, inst_valid}, 32'h0);
      checkOutput("rst_inst", Instruction, 32'h0);
      checkOutput("rst_link", link_addr, 32'h0);
      checkOutput("rst_err", {31'h0, fetch_err}, 32'h0);

      // Sequential fetch
      fetchWord(32'h2008_0001);
      checkOutput("pc_plus_4", PC_plus_4, 32'h0000_0004);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0000_0004);
      fetchWord(32'h2009_0002);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0000_0008);
      fetchWord(32'h012A_4020);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0000_000C);
      fetchWord(32'h0000_0000);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0000_0010);

      // Branch taken, not taken, bne taken
      fetchWord(32'h1109_000B);
      applyStimulus(0, 0, 0, 0, 1, 0, 1, 32'h0, 32'h0000_0040, 32'h0000_0040);
      fetchWord(32'h0320_0008);
      applyStimulus(0, 1, 0, 0, 0, 0, 0, 32'h0000_0010, 32'h0, 32'h0000_0010);
      fetchWord(32'h1109_000B);
      applyStimulus(0, 0, 0, 0, 1, 0, 0, 32'h0, 32'h0000_0040, 32'h0000_0014);
      fetchWord(32'h0320_0008);
      applyStimulus(0, 1, 0, 0, 0, 0, 0, 32'h0000_0010, 32'h0, 32'h0000_0010);
      fetchWord(32'h1509_000B);
      applyStimulus(0, 0, 0, 0, 0, 1, 0, 32'h0, 32'h0000_0040, 32'h0000_0040);

      // Jal, then Jr with a competing branch
      fetchWord(32'h0320_0008);
      applyStimulus(0, 1, 0, 0, 0, 0, 0, 32'h0040_0008, 32'h0, 32'h0040_0008);
      fetchWord(32'h0C00_0100);
      applyStimulus(0, 0, 0, 1, 0, 0, 0, 32'h0, 32'h0, 32'h0000_0400);
      checkOutput("link_addr", link_addr, 32'h0040_000C);
      fetchWord(32'h03E0_0008);
      applyStimulus(0, 1, 0, 0, 1, 0, 1, 32'h0040_000C, 32'h0000_0080, 32'h0040_000C);

      // Hold three cycles with a jump pending; stray acks in EXEC ignored
      fetchWord(32'h0800_0020);
      applyStimulus(3, 0, 1, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0000_0080);
      checkOutput("link_after_hold", link_addr, 32'h0040_000C);

      // Unaligned Jr target is word-aligned, then PC wraps past the top
      fetchWord(32'h0320_0008);
      applyStimulus(0, 1, 0, 0, 0, 0, 0, 32'hFFFF_FFFF, 32'h0, 32'hFFFF_FFFC);
      fetchWord(32'h0000_0000);
      checkOutput("wrap_pc_plus_4", PC_plus_4, 32'h0000_0000);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0000_0000);

      // Reset in a FETCH cycle with an ack present
      checkOutput("pre_rst_req", {31'h0, imem_req}, 32'h1);
      checkOutput("pre_rst_addr", imem_addr, addrQ.size() > 0 ? addrQ.pop_front() : 32'hxxxx_xxxx);
      reset = 1'b1;
      imem_ack = 1'b1;
      imem_rdata = 32'hDEAD_BEEF;
      @(negedge clock);
      reset = 1'b0;
      imem_ack = 1'b0;
      imem_rdata = 32'h0;
      checkOutput("midrst_inst", Instruction, 32'h0);
      checkOutput("midrst_valid", {31'h0, inst_valid}, 32'h0);
      checkOutput("midrst_req", {31'h0, imem_req}, 32'h1);
      checkOutput("midrst_addr", imem_addr, RESET_PC);
      checkOutput("midrst_link", link_addr, 32'h0);

      // Timeout with no ack
      applyReset();
      void'(addrQ.pop_front());
      for (int i = 0; i < FETCH_TIMEOUT; i++) begin
         checkOutput("to_wait_err", {31'h0, fetch_err}, 32'h0);
         checkOutput("to_wait_req", {31'h0, imem_req}, 32'h1);
         @(negedge clock);
      end
      checkOutput("to_err", {31'h0, fetch_err}, 32'h1);
      checkOutput("to_req", {31'h0, imem_req}, 32'h0);
      imem_ack = 1'b1;
      imem_rdata = 32'h1234_5678;
      Jmp = 1'b1;
      repeat (3) @(negedge clock);
      imem_ack = 1'b0;
      Jmp = 1'b0;
      checkOutput("halt_err", {31'h0, fetch_err}, 32'h1);
      checkOutput("halt_pc", imem_addr, RESET_PC);
      checkOutput("halt_valid", {31'h0, inst_valid}, 32'h0);
      checkOutput("halt_req", {31'h0, imem_req}, 32'h0);
      checkOutput("halt_inst", Instruction, 32'h0);

      applyReset();
      checkOutput("rec_err", {31'h0, fetch_err}, 32'h0);
      checkOutput("rec_addr", imem_addr, RESET_PC);
      fetchWord(32'h2008_0005);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
